alu_ctrl: RTL and testbench

//  Command-driven sequencer that drives the 8-bit ALU from the issuing side.

---
 rtl/alu_ctrl_pkg.sv | 46 ++++
 rtl/alu_ctrl_regfile.sv | 40 ++++
 rtl/alu_ctrl.sv | 155 +++++++++++++++
 tb/tb_alu_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU command sequencer: FSM states, ALU opcodes,
// condition codes and architectural flag bit positions.
package alu_ctrl_pkg;

   typedef enum logic [1:0] {
      ALU_CTRL_ST_IDLE = 2'd0,
      ALU_CTRL_ST_READ = 2'd1,
      ALU_CTRL_ST_EXEC = 2'd2,
      ALU_CTRL_ST_WB   = 2'd3
   } alu_ctrl_st_e;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_SHL = 4'd2;
   localparam logic [3:0] OP_SHR = 4'd3;
   localparam logic [3:0] OP_AND = 4'd4;
   localparam logic [3:0] OP_OR  = 4'd5;
   localparam logic [3:0] OP_XOR = 4'd6;

   localparam logic [1:0] ALU_CTRL_COND_ALWAYS = 2'd0;
   localparam logic [1:0] ALU_CTRL_COND_Z      = 2'd1;
   localparam logic [1:0] ALU_CTRL_COND_NZ     = 2'd2;
   localparam logic [1:0] ALU_CTRL_COND_C      = 2'd3;

   // Flag word layout is {Z,O,C,N}, matching the ALU's flag output.
   localparam int FLAG_Z = 3;
   localparam int FLAG_O = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_N = 0;

   function automatic logic op_legal(input logic [3:0] op);
      return op <= OP_XOR;
   endfunction

   function automatic logic cond_pass(input logic [1:0] cond, input logic [3:0] fl);
      logic pass;
      case (cond)
         ALU_CTRL_COND_Z:  pass = fl[FLAG_Z];
         ALU_CTRL_COND_NZ: pass = !fl[FLAG_Z];
         ALU_CTRL_COND_C:  pass = fl[FLAG_C];
         default:          pass = 1'b1;
      endcase
      return pass;
   endfunction

endpackage

// File: rtl/alu_ctrl_regfile.sv
// NREGS x DW register file: one synchronous write port, two combinational
// operand read ports and a combinational debug read port.
module alu_ctrl_regfile #(
   parameter  int NREGS = 8,
   parameter  int DW    = 8,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic [AW-1:0] raddr1_i,
   output logic [DW-1:0] rdata1_o,
   input  logic [AW-1:0] raddr2_i,
   output logic [DW-1:0] rdata2_o,
   input  logic [AW-1:0] dbg_addr_i,
   output logic [DW-1:0] dbg_data_o
);

   logic [DW-1:0] mem_q [NREGS];

   // NOTE: the array is reset because architectural registers must read 0
   // after reset; this keeps it in flops rather than a RAM macro.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we_i) begin
         // NOTE: state is updated with <= so every flop samples pre-edge values.
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata1_o   = mem_q[raddr1_i];
   assign rdata2_o   = mem_q[raddr2_i];
   assign dbg_data_o = mem_q[dbg_addr_i];

endmodule

// File: rtl/alu_ctrl.sv
// Command sequencer driving an external combinational ALU: IDLE->READ->EXEC->WB.
// Optional feature macro ALU_CTRL_COND_EN enables conditional execution via cmd_cond.
module alu_ctrl
   import alu_ctrl_pkg::*;
#(
   parameter  int NREGS = 8,
   parameter  int DW    = 8,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [3:0]    cmd_op,
   input  logic [AW-1:0] cmd_rd,
   input  logic [AW-1:0] cmd_rs1,
   input  logic [AW-1:0] cmd_rs2,
   input  logic          cmd_use_imm,
   input  logic [DW-1:0] cmd_imm,
   input  logic [1:0]    cmd_cond,
   output logic [3:0]    alu_operation,
   output logic [DW-1:0] alu_operand1,
   output logic [DW-1:0] alu_operand2,
   input  logic [DW-1:0] alu_result,
   input  logic [3:0]    alu_flags,
   output logic          done,
   output logic          err,
   output logic [3:0]    flags,
   input  logic [AW-1:0] dbg_addr,
   output logic [DW-1:0] dbg_data
);

   alu_ctrl_st_e  state_q, state_d;
   logic [3:0]    op_q;
   logic [AW-1:0] rd_q, rs1_q, rs2_q;
   logic          use_imm_q;
   logic [DW-1:0] imm_q, op1_q, op2_q, res_q;
   logic [3:0]    rflags_q, flags_q;
   logic          err_q, skip_q, cond_ok;
   logic [DW-1:0] rdata1, rdata2;

`ifdef ALU_CTRL_COND_EN
   logic [1:0]    cond_q;
   assign cond_ok = cond_pass(cond_q, flags_q);
`else
   logic          unused_cond;
   assign unused_cond = ^cmd_cond;
   assign cond_ok     = 1'b1;
`endif

   alu_ctrl_regfile #(.NREGS(NREGS), .DW(DW)) u_regfile (
      .clk        (clk),
      .rst        (rst),
      .we_i       (state_q == ALU_CTRL_ST_WB),
      .waddr_i    (rd_q),
      .wdata_i    (res_q),
      .raddr1_i   (rs1_q),
      .rdata1_o   (rdata1),
      .raddr2_i   (rs2_q),
      .rdata2_o   (rdata2),
      .dbg_addr_i (dbg_addr),
      .dbg_data_o (dbg_data)
   );

   always_comb begin
      // NOTE: every output gets a default before the case so no latch is inferred.
      state_d       = state_q;
      cmd_ready     = 1'b0;
      done          = skip_q;
      alu_operation = '0;
      alu_operand1  = '0;
      alu_operand2  = '0;
      case (state_q)
         ALU_CTRL_ST_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) state_d = ALU_CTRL_ST_READ;
         end
         ALU_CTRL_ST_READ:
            state_d = (op_legal(op_q) && cond_ok) ? ALU_CTRL_ST_EXEC : ALU_CTRL_ST_IDLE;
         ALU_CTRL_ST_EXEC: begin
            alu_operation = op_q;
            alu_operand1  = op1_q;
            alu_operand2  = op2_q;
            state_d       = ALU_CTRL_ST_WB;
         end
         ALU_CTRL_ST_WB: begin
            done    = 1'b1;
            state_d = ALU_CTRL_ST_IDLE;
         end
         default: state_d = ALU_CTRL_ST_IDLE;
      endcase
      // Reset is synchronous, so keep the outward handshake quiet during that cycle.
      if (rst) begin
         cmd_ready     = 1'b0;
         done          = 1'b0;
         alu_operation = '0;
         alu_operand1  = '0;
         alu_operand2  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ALU_CTRL_ST_IDLE;
         op_q      <= '0;
         rd_q      <= '0;
         rs1_q     <= '0;
         rs2_q     <= '0;
         use_imm_q <= 1'b0;
         imm_q     <= '0;
         op1_q     <= '0;
         op2_q     <= '0;
         res_q     <= '0;
         rflags_q  <= '0;
         flags_q   <= '0;
         err_q     <= 1'b0;
         skip_q    <= 1'b0;
`ifdef ALU_CTRL_COND_EN
         cond_q    <= '0;
`endif
      end else begin
         state_q <= state_d;
         err_q   <= (state_q == ALU_CTRL_ST_READ) && !op_legal(op_q);
         skip_q  <= (state_q == ALU_CTRL_ST_READ) && op_legal(op_q) && !cond_ok;
         case (state_q)
            ALU_CTRL_ST_IDLE: if (cmd_valid) begin
               op_q      <= cmd_op;
               rd_q      <= cmd_rd;
               rs1_q     <= cmd_rs1;
               rs2_q     <= cmd_rs2;
               use_imm_q <= cmd_use_imm;
               imm_q     <= cmd_imm;
`ifdef ALU_CTRL_COND_EN
               cond_q    <= cmd_cond;
`endif
            end
            // Operands are frozen here, so rd may alias rs1/rs2 safely.
            ALU_CTRL_ST_READ: begin
               op1_q <= rdata1;
               op2_q <= use_imm_q ? imm_q : rdata2;
            end
            ALU_CTRL_ST_EXEC: begin
               res_q    <= alu_result;
               rflags_q <= alu_flags;
            end
            ALU_CTRL_ST_WB: flags_q <= rflags_q;
            default: ;
         endcase
      end
   end

   assign err   = err_q && !rst;
   assign flags = flags_q;

endmodule

// File: tb/tb_alu_ctrl.sv
// Directed self-checking bench for alu_ctrl with a behavioural 8-bit ALU attached
// to its alu_* ports; build with ALU_CTRL_COND_EN to exercise conditional execution.
module tb_alu_ctrl;
   import alu_ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid, cmd_ready, cmd_use_imm;
   logic [3:0] cmd_op;
   logic [2:0] cmd_rd, cmd_rs1, cmd_rs2, dbg_addr;
   logic [7:0] cmd_imm, alu_operand1, alu_operand2, alu_result, dbg_data;
   logic [1:0] cmd_cond;
   logic [3:0] alu_operation, alu_flags, flags;
   logic       done, err;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   alu_ctrl dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
      .cmd_use_imm(cmd_use_imm), .cmd_imm(cmd_imm), .cmd_cond(cmd_cond),
      .alu_operation(alu_operation), .alu_operand1(alu_operand1),
      .alu_operand2(alu_operand2), .alu_result(alu_result), .alu_flags(alu_flags),
      .done(done), .err(err), .flags(flags),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   // Behavioural ALU: carry is carry-out on ADD, not-borrow on SUB, last bit out on shifts.
   logic [8:0] sum9;
   logic [7:0] m_res;
   logic       m_c, m_o;
   int         sh;
   always_comb begin
      sum9  = '0;
      m_res = '0;
      m_c   = 1'b0;
      m_o   = 1'b0;
      sh    = int'(alu_operand2[2:0]);
      case (alu_operation)
         OP_ADD: begin
            sum9  = {1'b0, alu_operand1} + {1'b0, alu_operand2};
            m_res = sum9[7:0];
            m_c   = sum9[8];
            m_o   = (alu_operand1[7] == alu_operand2[7]) && (m_res[7] != alu_operand1[7]);
         end
         OP_SUB: begin
            m_res = alu_operand1 - alu_operand2;
            m_c   = alu_operand1 >= alu_operand2;
            m_o   = (alu_operand1[7] != alu_operand2[7]) && (m_res[7] != alu_operand1[7]);
         end
         OP_SHL: begin
            m_res = alu_operand1 << sh;
            m_c   = (sh != 0) ? alu_operand1[8-sh] : 1'b0;
         end
         OP_SHR: begin
            m_res = alu_operand1 >> sh;
            m_c   = (sh != 0) ? alu_operand1[sh-1] : 1'b0;
         end
         OP_AND:  m_res = alu_operand1 & alu_operand2;
         OP_OR:   m_res = alu_operand1 | alu_operand2;
         OP_XOR:  m_res = alu_operand1 ^ alu_operand2;
         default: m_res = '0;
      endcase
      alu_result = m_res;
      alu_flags  = {m_res == 8'h00, m_o, m_c, m_res[7]};
   end

   typedef struct packed {
      logic [3:0] lat;
      logic       done;
      logic       err;
      logic       rdy;
      logic [3:0] x_op;
      logic [7:0] x_a;
      logic [7:0] x_b;
      logic [7:0] r_a;
      logic [7:0] pre;
   } res_t;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_reg(input string tag, input logic [2:0] idx, input logic [7:0] exp);
      dbg_addr = idx;
      #1;
      check(tag, dbg_data, exp);
   endtask

   // Called at a negedge in IDLE; returns at the negedge after the retire/err pulse.
   task automatic run_cmd(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                          input logic [2:0] rs2, input logic ui, input logic [7:0] imm,
                          input logic [1:0] cond, output res_t r);
      int wait_n;
      r        = '0;
      dbg_addr = rd;
      wait_n   = 0;
      while (!cmd_ready && wait_n < 8) begin
         @(negedge clk);
         wait_n++;
      end
      check("ready_before_cmd", cmd_ready, 1'b1);
      cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2;
      cmd_use_imm = ui; cmd_imm = imm; cmd_cond = cond;
      cmd_valid = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (k == 1) begin
            cmd_valid = 1'b0;
            r.r_a     = alu_operand1;
         end
         if (k == 2) begin
            r.x_op = alu_operation;
            r.x_a  = alu_operand1;
            r.x_b  = alu_operand2;
         end
         if (done || err) begin
            r.lat  = 4'(k);
            r.done = done;
            r.err  = err;
            r.rdy  = cmd_ready;
            r.pre  = dbg_data;
            break;
         end
      end
      @(negedge clk);
   endtask

   task automatic expect_retire(input string tag, input res_t r, input logic [3:0] lat,
                                input logic [2:0] rd, input logic [7:0] rexp,
                                input logic [3:0] fexp);
      check({tag, "_lat"},   r.lat, lat);
      check({tag, "_done"},  r.done, 1'b1);
      check({tag, "_err"},   r.err, 1'b0);
      check_reg({tag, "_reg"}, rd, rexp);
      check({tag, "_flags"}, flags, fexp);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      res_t r;
      logic saw_done;
      rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_rd = '0; cmd_rs1 = '0; cmd_rs2 = '0;
      cmd_use_imm = 1'b0; cmd_imm = '0; cmd_cond = '0; dbg_addr = '0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_ready", cmd_ready, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_err", err, 1'b0);
      check("rst_flags", flags, 4'h0);
      check("rst_aluop", alu_operation, 4'h0);
      check("rst_alua", alu_operand1, 8'h00);
      check("rst_alub", alu_operand2, 8'h00);
      for (int i = 0; i < 8; i++) check_reg($sformatf("rst_R%0d", i), 3'(i), 8'h00);
      rst = 1'b0;
      @(negedge clk);
      check("idle_ready", cmd_ready, 1'b1);

      // Preload R1=0x7F, R2=0x01 from R0
      run_cmd(OP_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 8'h7F, 2'd0, r);
      expect_retire("ld_R1", r, 4'd3, 3'd1, 8'h7F, 4'b0000);
      run_cmd(OP_ADD, 3'd2, 3'd0, 3'd0, 1'b1, 8'h01, 2'd0, r);
      expect_retire("ld_R2", r, 4'd3, 3'd2, 8'h01, 4'b0000);

      // Register-register ADD with signed overflow; immediate must be ignored
      run_cmd(OP_ADD, 3'd3, 3'd1, 3'd2, 1'b0, 8'h55, 2'd0, r);
      expect_retire("add", r, 4'd3, 3'd3, 8'h80, 4'b0101);
      check("add_read_quiet", r.r_a, 8'h00);
      check("add_exec_op", r.x_op, OP_ADD);
      check("add_exec_a", r.x_a, 8'h7F);
      check("add_exec_b", r.x_b, 8'h01);
      check("add_wb_ready", r.rdy, 1'b0);
      check("add_wb_prewrite", r.pre, 8'h00);

      // SUB to zero
      run_cmd(OP_ADD, 3'd4, 3'd0, 3'd0, 1'b1, 8'h05, 2'd0, r);
      expect_retire("ld_R4", r, 4'd3, 3'd4, 8'h05, 4'b0000);
      run_cmd(OP_SUB, 3'd5, 3'd4, 3'd0, 1'b1, 8'h05, 2'd0, r);
      expect_retire("sub", r, 4'd3, 3'd5, 8'h00, 4'b1010);

      // Shifts on 0x81
      run_cmd(OP_ADD, 3'd6, 3'd0, 3'd0, 1'b1, 8'h81, 2'd0, r);
      expect_retire("ld_R6", r, 4'd3, 3'd6, 8'h81, 4'b0001);
      run_cmd(OP_SHL, 3'd7, 3'd6, 3'd0, 1'b1, 8'h01, 2'd0, r);
      expect_retire("shl", r, 4'd3, 3'd7, 8'h02, 4'b0010);
      check("shl_exec_op", r.x_op, OP_SHL);
      run_cmd(OP_SHR, 3'd7, 3'd6, 3'd0, 1'b1, 8'h01, 2'd0, r);
      expect_retire("shr", r, 4'd3, 3'd7, 8'h40, 4'b0010);
      check("shr_wb_prewrite", r.pre, 8'h02);

      // rd aliases both sources: old R1 used for both operands
      run_cmd(OP_ADD, 3'd1, 3'd1, 3'd1, 1'b0, 8'h00, 2'd0, r);
      expect_retire("alias", r, 4'd3, 3'd1, 8'hFE, 4'b0101);

      // Illegal opcode: err pulse, nothing written
      run_cmd(4'hF, 3'd3, 3'd1, 3'd0, 1'b1, 8'h00, 2'd0, r);
      check("ill_lat", r.lat, 4'd2);
      check("ill_err", r.err, 1'b1);
      check("ill_done", r.done, 1'b0);
      check("ill_ready", r.rdy, 1'b1);
      check_reg("ill_R3", 3'd3, 8'h80);
      check("ill_flags", flags, 4'b0101);

      // Z=1 result, then conditional commands
      run_cmd(OP_SUB, 3'd5, 3'd0, 3'd0, 1'b1, 8'h00, 2'd0, r);
      expect_retire("zero", r, 4'd3, 3'd5, 8'h00, 4'b1010);
`ifdef ALU_CTRL_COND_EN
      run_cmd(OP_ADD, 3'd4, 3'd4, 3'd0, 1'b1, 8'h01, ALU_CTRL_COND_NZ, r);
      expect_retire("cond_nz_skip", r, 4'd2, 3'd4, 8'h05, 4'b1010);
      run_cmd(OP_ADD, 3'd4, 3'd4, 3'd0, 1'b1, 8'h01, ALU_CTRL_COND_Z, r);
      expect_retire("cond_z_exec", r, 4'd3, 3'd4, 8'h06, 4'b0000);
`else
      run_cmd(OP_ADD, 3'd4, 3'd4, 3'd0, 1'b1, 8'h01, ALU_CTRL_COND_NZ, r);
      expect_retire("cond_ignored_a", r, 4'd3, 3'd4, 8'h06, 4'b0000);
      run_cmd(OP_ADD, 3'd4, 3'd4, 3'd0, 1'b1, 8'h01, ALU_CTRL_COND_Z, r);
      expect_retire("cond_ignored_b", r, 4'd3, 3'd4, 8'h07, 4'b0000);
`endif

      // Reset during EXEC aborts the command
      dbg_addr = 3'd3;
      cmd_op = OP_ADD; cmd_rd = 3'd3; cmd_rs1 = 3'd1; cmd_use_imm = 1'b1; cmd_imm = 8'h01;
      cmd_cond = 2'd0; cmd_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      check("abort_in_exec", alu_operation, OP_ADD);
      rst = 1'b1;
      @(negedge clk);
      check("abort_rst_ready", cmd_ready, 1'b0);
      check("abort_rst_done", done, 1'b0);
      rst = 1'b0;
      saw_done = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (done) saw_done = 1'b1;
      end
      check("abort_no_done", saw_done, 1'b0);
      check("abort_ready", cmd_ready, 1'b1);
      check_reg("abort_R3", 3'd3, 8'h00);
      check("abort_flags", flags, 4'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
